// File: rtl/vga_capture_decoder.sv
// Receive-side VGA decoder: samples an incoming VGA stream, rebuilds sx/sy and
// verifies active-area geometry every line and frame before asserting locked.
//
// state   | meaning
// --------+------------------------------------------------------------------
// SEARCH  | waiting for the first vsync edge to start a measurement frame
// MEASURE | counting one full frame; lock only if every line and the frame fit
// LOCKED  | geometry verified; any line/frame mismatch or timeout drops lock

module vga_capture_decoder #(
   parameter int CORDW        = 10,
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int SYNC_POL     = 0,
   parameter int LINE_TIMEOUT = 1023
) (
   input  logic             clk_pix,
   input  logic             rst_n,
   input  logic             vga_hsync,
   input  logic             vga_vsync,
   input  logic             vga_de,
   input  logic [3:0]       vga_r,
   input  logic [3:0]       vga_g,
   input  logic [3:0]       vga_b,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             de,
   output logic [3:0]       pix_r,
   output logic [3:0]       pix_g,
   output logic [3:0]       pix_b,
   output logic             frame_start,
   output logic             locked,
   output logic             error
);

   localparam int              TW       = $clog2(LINE_TIMEOUT + 1);
   localparam logic [CORDW-1:0] CORD_MAX = '1;
   localparam logic [CORDW-1:0] H_RES_C  = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_RES_C  = CORDW'(V_RES);
   localparam logic [TW-1:0]    TMO_MAX  = TW'(LINE_TIMEOUT);
   localparam logic             POL_HIGH = (SYNC_POL != 0);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_MEASURE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic       hs1_q, vs1_q, de1_q;
   logic       hs_prev_q, vs_prev_q, de_prev_q;
   logic [3:0] r1_q, g1_q, b1_q;

   logic [CORDW-1:0] sx_q, sx_d;
   logic [CORDW-1:0] sy_q, sy_d;
   logic [CORDW-1:0] act_w_q, act_w_d;
   logic [CORDW-1:0] act_h_q, act_h_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             mism_q, mism_d;

   logic       de_q;
   logic [3:0] pix_r_q, pix_g_q, pix_b_q;
   logic       fs_q, locked_q, error_q;

   logic             hs_edge, vs_edge, de_rise, de_fall;
   logic             timeout, w_bad, h_bad, mism_now;
   logic [CORDW-1:0] act_h_upd;

   // Stage 1: input register with syncs normalised to active-high.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         hs1_q     <= 1'b0;
         vs1_q     <= 1'b0;
         de1_q     <= 1'b0;
         r1_q      <= '0;
         g1_q      <= '0;
         b1_q      <= '0;
         hs_prev_q <= 1'b0;
         vs_prev_q <= 1'b0;
         de_prev_q <= 1'b0;
      end else begin
         hs1_q     <= POL_HIGH ? vga_hsync : ~vga_hsync;
         vs1_q     <= POL_HIGH ? vga_vsync : ~vga_vsync;
         de1_q     <= vga_de;
         r1_q      <= vga_r;
         g1_q      <= vga_g;
         b1_q      <= vga_b;
         hs_prev_q <= hs1_q;
         vs_prev_q <= vs1_q;
         de_prev_q <= de1_q;
      end
   end

   always_comb begin
      hs_edge   = hs1_q & ~hs_prev_q;
      vs_edge   = vs1_q & ~vs_prev_q;
      de_rise   = de1_q & ~de_prev_q;
      de_fall   = ~de1_q & de_prev_q;
      timeout   = (tmo_q == TMO_MAX);
      w_bad     = de_fall & (act_w_q != H_RES_C);
      // A de_fall coinciding with vs_edge belongs to the frame being checked.
      act_h_upd = (de_fall && act_h_q != CORD_MAX) ? act_h_q + CORDW'(1) : act_h_q;
      h_bad     = (act_h_upd != V_RES_C);
      mism_now  = mism_q | w_bad;
   end

   always_comb begin
      sx_d    = sx_q;
      sy_d    = sy_q;
      act_w_d = act_w_q;
      act_h_d = act_h_upd;
      mism_d  = mism_now;
      tmo_d   = tmo_q;

      if (de_rise)
         sx_d = '0;
      else if (de1_q && sx_q != CORD_MAX)
         sx_d = sx_q + CORDW'(1);

      if (vs_edge)
         sy_d = '0;
      else if (de_fall && sy_q != CORD_MAX)
         sy_d = sy_q + CORDW'(1);

      if (de_rise)
         act_w_d = CORDW'(1);
      else if (de1_q && act_w_q != CORD_MAX)
         act_w_d = act_w_q + CORDW'(1);

      // Every vsync edge opens a fresh measurement window.
      if (vs_edge) begin
         act_h_d = '0;
         mism_d  = 1'b0;
      end

      if (hs_edge)
         tmo_d = '0;
      else if (!timeout)
         tmo_d = tmo_q + TW'(1);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_SEARCH: begin
            if (vs_edge)
               state_d = S_MEASURE;
         end
         S_MEASURE: begin
            if (timeout)
               state_d = S_SEARCH;
            else if (vs_edge && !mism_now && !h_bad)
               state_d = S_LOCKED;
         end
         S_LOCKED: begin
            if (timeout || w_bad || (vs_edge && h_bad))
               state_d = S_SEARCH;
         end
         default: state_d = S_SEARCH;
      endcase
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_SEARCH;
         sx_q    <= '0;
         sy_q    <= '0;
         act_w_q <= '0;
         act_h_q <= '0;
         mism_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         act_w_q <= act_w_d;
         act_h_q <= act_h_d;
         mism_q  <= mism_d;
         tmo_q   <= tmo_d;
      end
   end

   // Stage 2: output register; error fires on the cycle locked falls.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         de_q     <= 1'b0;
         pix_r_q  <= '0;
         pix_g_q  <= '0;
         pix_b_q  <= '0;
         fs_q     <= 1'b0;
         locked_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         de_q     <= de1_q;
         pix_r_q  <= de1_q ? r1_q : 4'd0;
         pix_g_q  <= de1_q ? g1_q : 4'd0;
         pix_b_q  <= de1_q ? b1_q : 4'd0;
         fs_q     <= (state_q == S_LOCKED) && de1_q && (sx_d == '0) && (sy_d == '0);
         locked_q <= (state_q == S_LOCKED);
         error_q  <= locked_q && (state_q != S_LOCKED);
      end
   end

   assign sx          = sx_q;
   assign sy          = sy_q;
   assign de          = de_q;
   assign pix_r       = pix_r_q;
   assign pix_g       = pix_g_q;
   assign pix_b       = pix_b_q;
   assign frame_start = fs_q;
   assign locked      = locked_q;
   assign error       = error_q;

endmodule
